// File: rtl/inst_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : inst_queue_pkg                                           |
// | Purpose  : Shared sizing constants for the IF->ID instruction queue |
// |            (instruction address bus, instruction bus, queue depth). |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package inst_queue_pkg;

   // Instruction address bus width (pc).
   localparam int INST_ADDR_W      = 32;
   // Instruction bus width.
   localparam int INST_DATA_W      = 32;
   // Default number of queue entries (power of two, >= 2).
   localparam int INST_QUEUE_DEPTH = 4;

endpackage : inst_queue_pkg
`default_nettype wire

// File: rtl/inst_queue_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : inst_queue_mem                                           |
// | Purpose  : DEPTH x WIDTH register array for the instruction queue.  |
// |            One synchronous write port, one asynchronous read port.  |
// |            Data is not reset; entries are don't-care until written. |
// | Ports    : clk    in   clock                                        |
// |            we     in   write enable                                 |
// |            waddr  in   write index                                  |
// |            wdata  in   write data                                   |
// |            raddr  in   read index                                   |
// |            rdata  out  read data (combinational)                    |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module inst_queue_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : inst_queue_mem
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : inst_queue                                               |
// | Purpose  : IF->ID instruction queue. Buffers up to DEPTH {pc,inst}  |
// |            pairs from fetch and presents them in order to decode    |
// |            with a valid/ready handshake (show-ahead head).          |
// |            Backpressures fetch with full_o; flush or a taken branch |
// |            discards every entry.                                    |
// | Config   : INST_QUEUE_BYPASS_EN - when defined, an empty queue      |
// |            forwards pc_i/inst_i to the head outputs in the same     |
// |            cycle (zero latency). Undefined: 1-cycle min latency.    |
// | Ports    : clk            in   clock                                |
// |            rst            in   asynchronous reset, active low       |
// |            flush          in   drop all contents                    |
// |            branch_flag_i  in   taken branch, drop all contents      |
// |            pc_i           in   fetched pc                           |
// |            pc_valid_i     in   pc_i/inst_i carry an instruction     |
// |            inst_i         in   fetched instruction                  |
// |            full_o         out  queue full, fetch must hold          |
// |            id_ready_i     in   decode accepts head this cycle       |
// |            pc_o           out  head pc (0 when not valid)           |
// |            inst_o         out  head instruction (0 when not valid)  |
// |            inst_valid_o   out  head valid                           |
// |            count_o        out  occupancy                            |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH  = INST_QUEUE_DEPTH,
   parameter int ADDR_W = INST_ADDR_W,
   parameter int INST_W = INST_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       branch_flag_i,
   input  logic [ADDR_W-1:0]          pc_i,
   input  logic                       pc_valid_i,
   input  logic [INST_W-1:0]          inst_i,
   output logic                       full_o,
   input  logic                       id_ready_i,
   output logic [ADDR_W-1:0]          pc_o,
   output logic [INST_W-1:0]          inst_o,
   output logic                       inst_valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   // One bit wider than the pointers so full and empty are distinct.
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + INST_W;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             kill;
   logic             empty;
   logic             push;
   logic             pop;
   logic             bypass;
   logic             store_wr;
   logic             store_rd;
   logic [ENT_W-1:0] head_data;

   assign kill   = flush | branch_flag_i;
   assign empty  = (count == '0);
   // Full comes from the registered count only, so a same-cycle pop
   // never re-opens a slot for the push in that cycle.
   assign full_o = (count == CNT_W'(DEPTH));

   assign push = pc_valid_i & ~full_o;
   assign pop  = inst_valid_o & id_ready_i;

`ifdef INST_QUEUE_BYPASS_EN
   // Gated by rst so the outputs read zero while reset is held.
   assign bypass = empty & pc_valid_i & ~kill & rst;

   assign inst_valid_o = ~empty | bypass;
   assign pc_o   = bypass ? pc_i   : (empty ? '0 : head_data[ENT_W-1:INST_W]);
   assign inst_o = bypass ? inst_i : (empty ? '0 : head_data[INST_W-1:0]);
`else
   assign bypass = 1'b0;

   assign inst_valid_o = ~empty;
   assign pc_o   = empty ? '0 : head_data[ENT_W-1:INST_W];
   assign inst_o = empty ? '0 : head_data[INST_W-1:0];
`endif

   // A bypassed instruction consumed in the same cycle is never stored;
   // a pop while empty can only be the bypass path, so storage is untouched.
   assign store_wr = push & ~kill & ~(bypass & id_ready_i);
   assign store_rd = pop & ~empty & ~kill;

   assign count_o = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (kill) begin
         // Same-cycle push and pop are both discarded.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (store_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (store_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(store_wr) - CNT_W'(store_rd);
      end
   end

   inst_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (store_wr),
      .waddr (wr_ptr),
      .wdata ({pc_i, inst_i}),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

endmodule : inst_queue
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_inst_queue                                            |
// | Purpose  : Self-checking bench for inst_queue. Directed scenarios   |
// |            (reset, fill, drain order, simultaneous push/pop,        |
// |            branch discard, empty-queue latency) followed by random  |
// |            traffic, all compared against a queue-based model.       |
// | Config   : honours INST_QUEUE_BYPASS_EN like the design.            |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_inst_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        pc_valid_i = 1'b0;
   logic [31:0] inst_i = '0;
   logic        id_ready_i = 1'b0;
   logic        full_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic [2:0]  count_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t model[$];

   inst_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .branch_flag_i (branch_flag_i),
      .pc_i          (pc_i),
      .pc_valid_i    (pc_valid_i),
      .inst_i        (inst_i),
      .full_o        (full_o),
      .id_ready_i    (id_ready_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, compare outputs against the model, then
   // advance the model by the queue rules and step past the clock edge.
   task automatic cycle(input logic fl, input logic br, input logic pv,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy);
      int   sz;
      logic byp;
      logic exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic popped;
      logic pushed;
      flush = fl; branch_flag_i = br; pc_valid_i = pv;
      pc_i = pc; inst_i = inst; id_ready_i = rdy;
      #1;
      sz  = model.size();
      byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      byp = (sz == 0) && pv && !(fl || br);
`endif
      exp_valid = (sz != 0) || byp;
      exp_pc    = (sz != 0) ? model[0].pc   : (byp ? pc   : 32'h0);
      exp_inst  = (sz != 0) ? model[0].inst : (byp ? inst : 32'h0);
      chk("valid", 32'(inst_valid_o), 32'(exp_valid));
      chk("pc",    pc_o,   exp_pc);
      chk("inst",  inst_o, exp_inst);
      chk("count", 32'(count_o), 32'(sz));
      chk("full",  32'(full_o),  32'(sz == DEPTH));
      if (fl || br) begin
         model.delete();
      end else begin
         popped = exp_valid && rdy;
         pushed = pv && (sz < DEPTH);
         if (popped && sz != 0) void'(model.pop_front());
         if (pushed && !(byp && popped)) model.push_back('{pc, inst});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(inst_valid_o), 32'h0);
      chk("rst_pc",    pc_o, 32'h0);
      chk("rst_inst",  inst_o, 32'h0);
      chk("rst_count", 32'(count_o), 32'h0);
      chk("rst_full",  32'(full_o), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous reset mid-run with three entries held.
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h1b000000 + i * 4, $urandom, 0);
      chk("pre_arst_count", 32'(count_o), 32'd3);
      pc_valid_i = 1'b0; id_ready_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(inst_valid_o), 32'h0);
      chk("arst_pc",    pc_o, 32'h0);
      chk("arst_inst",  inst_o, 32'h0);
      chk("arst_count", 32'(count_o), 32'h0);
      chk("arst_full",  32'(full_o), 32'h0);
      model.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Fill to full; the fifth push is dropped.
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h1c000000 + i * 4, $urandom, 0);
      chk("fill_count", 32'(count_o), 32'd4);
      chk("fill_full",  32'(full_o), 32'd1);
      cycle(0, 0, 1, 32'h1c000010, $urandom, 0);
      chk("drop_count", 32'(count_o), 32'd4);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", pc_o, 32'h1c000000 + i * 4);
         cycle(0, 0, 0, 32'h0, 32'h0, 1);
      end
      chk("drain_empty", 32'(inst_valid_o), 32'h0);

      // Simultaneous push and pop.
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h1c000100 + i * 4, $urandom, 0);
      cycle(0, 0, 1, 32'h1c000200, $urandom, 1);
      chk("full_pushpop_count", 32'(count_o), 32'd3);
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      chk("pop_count", 32'(count_o), 32'd2);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, 32'h1c000300 + i * 4, $urandom, 1);
         chk("pushpop_count", 32'(count_o), 32'd2);
      end
      cycle(0, 0, 1, 32'h1c000400, $urandom, 0);
      chk("pre_branch_count", 32'(count_o), 32'd3);

      // Taken branch with a concurrent push.
      cycle(0, 1, 1, 32'h1c000020, $urandom, 0);
      chk("branch_count", 32'(count_o), 32'd0);
      chk("branch_valid", 32'(inst_valid_o), 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 32'h0, 1);

      // Push into an empty queue with decode ready.
      flush = 1'b0; branch_flag_i = 1'b0;
      pc_valid_i = 1'b1; pc_i = 32'h1c000040; inst_i = 32'h00a0_0513; id_ready_i = 1'b1;
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      chk("byp_valid", 32'(inst_valid_o), 32'd1);
      chk("byp_pc",    pc_o, 32'h1c000040);
      chk("byp_inst",  inst_o, 32'h00a0_0513);
`else
      chk("nobyp_valid", 32'(inst_valid_o), 32'd0);
      chk("nobyp_pc",    pc_o, 32'h0);
`endif
      @(posedge clk);
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      chk("byp_count_after", 32'(count_o), 32'd0);
      chk("byp_valid_after", 32'(inst_valid_o), 32'd0);
`else
      chk("nobyp_valid_after", 32'(inst_valid_o), 32'd1);
      chk("nobyp_pc_after",    pc_o, 32'h1c000040);
      chk("nobyp_count_after", 32'(count_o), 32'd1);
      model.push_back('{32'h1c000040, 32'h00a0_0513});
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 9) < 7), $urandom, $urandom,
               ($urandom_range(0, 1) == 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_inst_queue
`default_nettype wire
